// File: rtl/unified_mem.sv
// Single-port word memory shared by instruction fetch and data ports, with
// grant/latency/response sequencing. MEM_ARB_RR_EN selects round-robin arbitration.
module unified_mem #(
  parameter int unsigned WORDS   = 100,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_read,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_out,
  output logic        instr_ready,
  input  logic        data_read,
  input  logic [3:0]  data_write,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int unsigned AW       = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [2:0]  CNT_LOAD = 3'(LATENCY - 1);

  logic [31:0] mem_q [WORDS];

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        gnt_data_q, gnt_data_d;
  logic [29:0] idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        wr_q, wr_d;
  logic [31:0] instr_out_q, instr_out_d;
  logic [31:0] data_out_q, data_out_d;
  logic        instr_ready_q, instr_ready_d;
  logic        data_ready_q, data_ready_d;

  logic        instr_req, data_req, any_req, pick_data;
  logic        access, in_range;
  logic [31:0] rd_word;
  logic        unused_addr_bits;

  assign instr_req = instr_read;
  assign data_req  = data_read | (|data_write);
  assign any_req   = instr_req | data_req;

`ifdef MEM_ARB_RR_EN
  logic last_instr_q, last_instr_d;
  // On conflict the port that did not win the previous grant goes first.
  assign pick_data = data_req & (~instr_req | last_instr_q);
`else
  assign pick_data = data_req;
`endif

  assign access   = (state_q == WAIT) && (cnt_q == '0);
  assign in_range = ({2'b00, idx_q} < 32'(WORDS));
  assign rd_word  = in_range ? mem_q[idx_q[AW-1:0]] : '0;

  assign unused_addr_bits = ^{instr_addr[1:0], data_addr[1:0]};

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    gnt_data_d    = gnt_data_q;
    idx_d         = idx_q;
    wdata_d       = wdata_q;
    be_d          = be_q;
    wr_d          = wr_q;
    instr_out_d   = instr_out_q;
    data_out_d    = data_out_q;
    instr_ready_d = 1'b0;
    data_ready_d  = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_instr_d  = last_instr_q;
`endif
    case (state_q)
      IDLE, RESP: begin
        if (any_req) begin
          gnt_data_d = pick_data;
          idx_d      = pick_data ? data_addr[31:2] : instr_addr[31:2];
          wdata_d    = data_in;
          be_d       = pick_data ? data_write : 4'b0000;
          wr_d       = pick_data & (|data_write);
          cnt_d      = CNT_LOAD;
          state_d    = WAIT;
`ifdef MEM_ARB_RR_EN
          last_instr_d = ~pick_data;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          if (gnt_data_q) begin
            data_ready_d = 1'b1;
            if (!wr_q) data_out_d = rd_word;
          end else begin
            instr_ready_d = 1'b1;
            instr_out_d   = rd_word;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      gnt_data_q    <= 1'b0;
      idx_q         <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
      wr_q          <= 1'b0;
      instr_out_q   <= '0;
      data_out_q    <= '0;
      instr_ready_q <= 1'b0;
      data_ready_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_instr_q  <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      gnt_data_q    <= gnt_data_d;
      idx_q         <= idx_d;
      wdata_q       <= wdata_d;
      be_q          <= be_d;
      wr_q          <= wr_d;
      instr_out_q   <= instr_out_d;
      data_out_q    <= data_out_d;
      instr_ready_q <= instr_ready_d;
      data_ready_q  <= data_ready_d;
`ifdef MEM_ARB_RR_EN
      last_instr_q  <= last_instr_d;
`endif
    end
  end

  // Array has no reset; a reset sampled on the access edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && access && wr_q && in_range) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_q[b]) mem_q[idx_q[AW-1:0]][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign instr_out   = instr_out_q;
  assign instr_ready = instr_ready_q;
  assign data_out    = data_out_q;
  assign data_ready  = data_ready_q;

endmodule
